exe_stage: RTL and testbench

EXE_STAGE -- requirements
Module: exe_stage

---
 rtl/cpu_pkg.sv | 19 +
 rtl/exe_stage_alu.sv | 45 ++++
 rtl/exe_stage.sv | 150 +++++++++++++++
 tb/tb_exe_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and ALU command encodings
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0010,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_NOR = 4'b0110,
        ALU_XOR = 4'b0111,
        ALU_SHL = 4'b1000,
        ALU_SRA = 4'b1001,
        ALU_SRL = 4'b1010
    } alu_cmd_e;

endpackage

// File: rtl/exe_stage_alu.sv
// rtl/exe_stage_alu.sv - combinational ALU for the execute stage
//
// Ports:
//   cmd_i    - ALU command (cpu_pkg::alu_cmd_e encoding; unknown codes give 0)
//   a_i      - operand 1
//   b_i      - operand 2; also the full-width shift amount
//   result_o - ALU result
module exe_stage_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    localparam int SH_W = $clog2(DATA_W);

    // Any set bit above the low SH_W bits means the shift moves every bit out.
    logic            shift_big;
    logic [SH_W-1:0] sh_amt;

    assign shift_big = |b_i[DATA_W-1:SH_W];
    assign sh_amt    = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        case (cmd_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_SHL: result_o = shift_big ? '0 : (a_i << sh_amt);
            ALU_SRL: result_o = shift_big ? '0 : (a_i >> sh_amt);
            ALU_SRA: result_o = shift_big ? {DATA_W{a_i[DATA_W-1]}}
                                          : DATA_W'($signed(a_i) >>> sh_amt);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: operand forwarding, ALU, EX/MEM register, load-use detect
//
// Ports:
//   clk, rst            - clock; synchronous active-low reset
//   freeze, flush       - hold the EX/MEM register / load a bubble
//   id_*                - decoded operation from the ID stage
//   mem_*, wb_*         - forwarding sources from the MEM and WB stages
//   ex_*                - registered EX/MEM outputs
//   hazard              - combinational load-use stall request to upstream
module exe_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = cpu_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_cmd,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_imm_sel,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r,
    input  logic              id_mem_w,
    input  logic              mem_wb_en,
    input  logic [REG_W-1:0]  mem_dest,
    input  logic [DATA_W-1:0] mem_value,
    input  logic              wb_wb_en,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] ex_store_val,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_wb_en,
    output logic              ex_mem_r,
    output logic              ex_mem_w,
    output logic              hazard
);

    logic [DATA_W-1:0] op1_fwd;
    logic [DATA_W-1:0] op2_fwd;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q,  store_d;
    logic [REG_W-1:0]  dest_q,   dest_d;
    logic              wb_en_q,  wb_en_d;
    logic              mem_r_q,  mem_r_d;
    logic              mem_w_q,  mem_w_d;

    // MEM holds the younger result, so it wins over WB on a double match.
    always_comb begin
        op1_fwd = id_val1;
        if (mem_wb_en && (mem_dest == id_src1)) begin
            op1_fwd = mem_value;
        end else if (wb_wb_en && (wb_dest == id_src1)) begin
            op1_fwd = wb_value;
        end

        op2_fwd = id_val2;
        if (mem_wb_en && (mem_dest == id_src2)) begin
            op2_fwd = mem_value;
        end else if (wb_wb_en && (wb_dest == id_src2)) begin
            op2_fwd = wb_value;
        end
    end

    assign alu_b = id_imm_sel ? id_imm : op2_fwd;

    exe_stage_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .cmd_i   (id_cmd),
        .a_i     (op1_fwd),
        .b_i     (alu_b),
        .result_o(alu_res)
    );

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        store_d  = store_q;
        dest_d   = dest_q;
        wb_en_d  = wb_en_q;
        mem_r_d  = mem_r_q;
        mem_w_d  = mem_w_q;
        if (flush) begin
            valid_d  = 1'b0;
            result_d = '0;
            store_d  = '0;
            dest_d   = '0;
            wb_en_d  = 1'b0;
            mem_r_d  = 1'b0;
            mem_w_d  = 1'b0;
        end else if (!freeze) begin
            valid_d  = id_valid;
            result_d = alu_res;
            store_d  = op2_fwd;
            dest_d   = id_dest;
            wb_en_d  = id_wb_en & id_valid;
            mem_r_d  = id_mem_r & id_valid;
            mem_w_d  = id_mem_w & id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            dest_q   <= '0;
            wb_en_q  <= 1'b0;
            mem_r_q  <= 1'b0;
            mem_w_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            dest_q   <= dest_d;
            wb_en_q  <= wb_en_d;
            mem_r_q  <= mem_r_d;
            mem_w_q  <= mem_w_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_result    = result_q;
    assign ex_store_val = store_q;
    assign ex_dest      = dest_q;
    assign ex_wb_en     = wb_en_q;
    assign ex_mem_r     = mem_r_q;
    assign ex_mem_w     = mem_w_q;

    // A load in EX cannot forward its data yet. src2 only matters when it is
    // actually read: as ALU operand (no immediate) or as store data.
    assign hazard = id_valid && valid_q && mem_r_q &&
                    ((dest_q == id_src1) ||
                     ((dest_q == id_src2) && (!id_imm_sel || id_mem_w)));

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard testbench for exe_stage
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush;
    logic        id_valid;
    logic [3:0]  id_cmd;
    logic [31:0] id_val1, id_val2, id_imm;
    logic        id_imm_sel;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic        id_wb_en, id_mem_r, id_mem_w;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;
    logic [31:0] mem_value;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        ex_valid;
    logic [31:0] ex_result, ex_store_val;
    logic [3:0]  ex_dest;
    logic        ex_wb_en, ex_mem_r, ex_mem_w;
    logic        hazard;

    always #5 clk = ~clk;

    exe_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_cmd(id_cmd), .id_val1(id_val1), .id_val2(id_val2),
        .id_imm(id_imm), .id_imm_sel(id_imm_sel), .id_src1(id_src1), .id_src2(id_src2),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r), .id_mem_w(id_mem_w),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_val(ex_store_val),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r(ex_mem_r), .ex_mem_w(ex_mem_w),
        .hazard(hazard)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store;
        logic [3:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return ~(a | b);
            4'b0111: return a ^ b;
            4'b1000: return a << b;
            4'b1001: return $signed(a) >>> b;
            4'b1010: return a >> b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [3:0] src, input logic [31:0] v);
        if (mem_wb_en && mem_dest == src) return mem_value;
        if (wb_wb_en && wb_dest == src) return wb_value;
        return v;
    endfunction

    function automatic logic m_hazard();
        if (!(id_valid && m.valid && m.mr)) return 1'b0;
        if (m.dest == id_src1) return 1'b1;
        return (m.dest == id_src2) && (!id_imm_sel || id_mem_w);
    endfunction

    task automatic clear_inputs();
        freeze = 0; flush = 0; id_valid = 0; id_cmd = 0;
        id_val1 = 0; id_val2 = 0; id_imm = 0; id_imm_sel = 0;
        id_src1 = 0; id_src2 = 0; id_dest = 0;
        id_wb_en = 0; id_mem_r = 0; id_mem_w = 0;
        mem_wb_en = 0; mem_dest = 0; mem_value = 0;
        wb_wb_en = 0; wb_dest = 0; wb_value = 0;
    endtask

    // Inputs are driven just after a sampling point; hazard is checked once
    // they settle, the expected register value is queued, and the DUT output
    // is popped and compared 1 ns after the next rising edge.
    task automatic step(input string tag);
        exp_t e;
        logic [31:0] op1, op2;
        #1;
        check({tag, ".hazard"}, {31'b0, hazard}, {31'b0, m_hazard()});
        e = '0;
        if (!rst || flush) begin
            e = '0;
        end else if (freeze) begin
            e = m;
        end else begin
            op1      = m_fwd(id_src1, id_val1);
            op2      = m_fwd(id_src2, id_val2);
            e.valid  = id_valid;
            e.result = m_alu(id_cmd, op1, id_imm_sel ? id_imm : op2);
            e.store  = op2;
            e.dest   = id_dest;
            e.wb     = id_wb_en & id_valid;
            e.mr     = id_mem_r & id_valid;
            e.mw     = id_mem_w & id_valid;
        end
        q.push_back(e);
        m = e;
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, ".valid"},  {31'b0, ex_valid},     {31'b0, e.valid});
        check({tag, ".result"}, ex_result,             e.result);
        check({tag, ".store"},  ex_store_val,          e.store);
        check({tag, ".dest"},   {28'b0, ex_dest},      {28'b0, e.dest});
        check({tag, ".wb_en"},  {31'b0, ex_wb_en},     {31'b0, e.wb});
        check({tag, ".mem_r"},  {31'b0, ex_mem_r},     {31'b0, e.mr});
        check({tag, ".mem_w"},  {31'b0, ex_mem_w},     {31'b0, e.mw});
    endtask

    task automatic set_load(input logic [3:0] dest);
        clear_inputs();
        id_valid = 1; id_mem_r = 1; id_wb_en = 1; id_dest = dest;
        id_cmd = 4'b0000; id_val1 = 32'h100; id_imm_sel = 1; id_imm = 4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmds[6];
        cmds = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b0011, 4'b1111};
        m = '0;
        clear_inputs();
        rst = 0;
        step("reset0");
        step("reset1");
        check("reset.lit_valid", {31'b0, ex_valid}, 32'd0);
        rst = 1;

        // Plain add, no forwarding.
        clear_inputs();
        id_valid = 1; id_cmd = 4'b0000; id_val1 = 5; id_val2 = 7;
        id_src1 = 1; id_src2 = 2; id_dest = 5; id_wb_en = 1;
        step("add");
        check("add.lit_result", ex_result, 32'd12);
        check("add.lit_valid", {31'b0, ex_valid}, 32'd1);

        // MEM beats WB on the same destination.
        clear_inputs();
        id_valid = 1; id_src1 = 3; id_val1 = 7; id_imm_sel = 1; id_imm = 1;
        mem_wb_en = 1; mem_dest = 3; mem_value = 100;
        wb_wb_en = 1; wb_dest = 3; wb_value = 200;
        step("fwd_prio");
        check("fwd_prio.lit_result", ex_result, 32'd101);

        // MEM dest matches but wb_en=0: ignored. WB forwards src2 (store too).
        clear_inputs();
        id_valid = 1; id_cmd = 4'b0010; id_src1 = 3; id_val1 = 9;
        id_src2 = 4; id_val2 = 1; id_mem_w = 1;
        mem_dest = 3; mem_value = 100;
        wb_wb_en = 1; wb_dest = 4; wb_value = 55;
        step("fwd_wb");
        check("fwd_wb.lit_result", ex_result, 32'hFFFF_FFD2);
        check("fwd_wb.lit_store", ex_store_val, 32'd55);

        // Shifts.
        clear_inputs();
        id_valid = 1; id_val1 = 32'h8000_0000; id_imm_sel = 1; id_imm = 4;
        id_cmd = 4'b1001; step("sra4");
        check("sra4.lit", ex_result, 32'hF800_0000);
        id_cmd = 4'b1010; step("srl4");
        check("srl4.lit", ex_result, 32'h0800_0000);
        id_cmd = 4'b1000; id_imm = 32; step("shl32");
        check("shl32.lit", ex_result, 32'h0);
        id_cmd = 4'b1001; id_imm = 40; step("sra40");
        check("sra40.lit", ex_result, 32'hFFFF_FFFF);
        id_cmd = 4'b1010; id_imm = 32'h1_0000; step("srl_huge");

        // Logic ops and undefined codes.
        clear_inputs();
        id_valid = 1; id_val1 = 32'hF0F0_A5A5; id_val2 = 32'h0FF0_FF00;
        for (int i = 0; i < 6; i++) begin
            id_cmd = cmds[i];
            step($sformatf("logic%0d", i));
        end
        check("undef.lit", ex_result, 32'h0);

        // Load-use on src1, resolved by flush.
        set_load(2);
        step("load_a");
        clear_inputs();
        id_valid = 1; id_src1 = 2; id_dest = 6; id_wb_en = 1;
        #1;
        check("loaduse.lit_hazard", {31'b0, hazard}, 32'd1);
        flush = 1;
        step("loaduse_flush");
        check("loaduse.lit_valid", {31'b0, ex_valid}, 32'd0);

        // src2 with immediate: hazard only for a store.
        set_load(2);
        step("load_b");
        clear_inputs();
        id_valid = 1; id_src1 = 7; id_src2 = 2; id_imm_sel = 1; id_mem_w = 0;
        #1;
        check("src2_imm.lit_hazard", {31'b0, hazard}, 32'd0);
        id_mem_w = 1;
        #1;
        check("src2_store.lit_hazard", {31'b0, hazard}, 32'd1);
        flush = 1;
        step("src2_flush");

        // Freeze holds for three cycles while inputs change.
        clear_inputs();
        id_valid = 1; id_val1 = 1; id_val2 = 2; id_dest = 9; id_wb_en = 1;
        step("pre_freeze");
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            id_val1 = $urandom; id_cmd = 4'b0111; id_dest = 4'(i);
            step($sformatf("freeze%0d", i));
            check($sformatf("freeze%0d.lit", i), ex_result, 32'd3);
        end
        flush = 1;
        step("flush_freeze");
        check("flush_freeze.lit_valid", {31'b0, ex_valid}, 32'd0);

        // Reset overrides freeze; the op on the release edge is accepted.
        clear_inputs();
        id_valid = 1; id_val1 = 10; id_val2 = 20; id_wb_en = 1; id_dest = 3;
        step("pre_reset");
        rst = 0; freeze = 1;
        step("reset_freeze");
        check("reset_freeze.lit_result", ex_result, 32'd0);
        rst = 1; freeze = 0; id_val1 = 40;
        step("reset_release");
        check("reset_release.lit_result", ex_result, 32'd60);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            rst        = ($urandom_range(0, 19) != 0);
            flush      = ($urandom_range(0, 7) == 0);
            freeze     = ($urandom_range(0, 5) == 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_cmd     = 4'($urandom_range(0, 15));
            id_val1    = $urandom;
            id_val2    = $urandom;
            id_imm     = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom;
            id_imm_sel = 1'($urandom_range(0, 1));
            id_src1    = 4'($urandom_range(0, 3));
            id_src2    = 4'($urandom_range(0, 3));
            id_dest    = 4'($urandom_range(0, 3));
            id_wb_en   = 1'($urandom_range(0, 1));
            id_mem_r   = 1'($urandom_range(0, 1));
            id_mem_w   = 1'($urandom_range(0, 1));
            mem_wb_en  = 1'($urandom_range(0, 1));
            mem_dest   = 4'($urandom_range(0, 3));
            mem_value  = $urandom;
            wb_wb_en   = 1'($urandom_range(0, 1));
            wb_dest    = 4'($urandom_range(0, 3));
            wb_value   = $urandom;
            step($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
